// File: rtl/i281_pkg.sv
// Shared definitions for the i281 code loader: instruction layout, framing
// constants, FSM encoding and error codes.
package i281_pkg;

  localparam int INSTR_W    = 17;
  localparam int PAD_BIT    = 16;
  localparam int OPCODE_LSB = 12;
  localparam int RX_LSB     = 10;
  localparam int RY_LSB     = 8;
  localparam int IMM_LSB    = 0;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_COUNT,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_COUNT  = 2'd1,
    ERR_FORMAT = 2'd2,
    ERR_SUM    = 2'd3
  } err_t;

endpackage

// File: rtl/i281_word_assembler.sv
// Packs three big-endian stream bytes into one 17-bit i281 instruction word
// and flags a malformed first byte (only bit 0 may be set).
module i281_word_assembler
  import i281_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_byte,
  input  logic               load_b0,
  input  logic               load_b1,
  output logic               fmt_ok,
  output logic [INSTR_W-1:0] word
);

  logic       b0_bit;
  logic [7:0] b1_q;

  assign fmt_ok = (in_byte[7:1] == 7'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      b0_bit <= 1'b0;
      b1_q   <= 8'd0;
    end else begin
      if (load_b0) b0_bit <= in_byte[0];
      if (load_b1) b1_q   <= in_byte;
    end
  end

  // The third byte is taken straight from the stream so the word is complete
  // on the cycle that byte is consumed.
  always_comb begin
    word                   = '0;
    word[PAD_BIT]          = b0_bit;
    word[OPCODE_LSB +: 4]  = b1_q[7:4];
    word[RX_LSB +: 2]      = b1_q[3:2];
    word[RY_LSB +: 2]      = b1_q[1:0];
    word[IMM_LSB +: 8]     = in_byte;
  end

endmodule

// File: rtl/i281_code_loader.sv
// Framed byte-stream loader for i281 code memory. Valid/ready: a byte moves on
// any cycle with in_valid && in_ready; in_ready drops only during the write cycle.
module i281_code_loader
  import i281_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         WORDS     = 32,
  parameter int         ADDR_W    = 5,
  parameter int         BASE_ADDR = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err,
  output state_t             dbg_state
);

  localparam int         CNT_W   = $clog2(WORDS + 1);
  localparam logic [7:0] WORDS_B = 8'(WORDS);

  state_t             state, state_nx;
  err_t               err_q;
  logic [CNT_W-1:0]   count, idx;
  logic [7:0]         csum;
  logic               consume, count_bad, last_word, is_sync;
  logic               load_b0, load_b1, fmt_ok;
  logic [INSTR_W-1:0] word;
  logic [CNT_W:0]     addr_sum;

  assign consume   = in_valid && in_ready;
  assign is_sync   = (in_data == SYNC_BYTE);
  assign count_bad = (in_data == 8'd0) || (in_data > WORDS_B);
  assign last_word = ((idx + CNT_W'(1)) == count);
  assign addr_sum  = (CNT_W+1)'(BASE_ADDR) + (CNT_W+1)'(idx);
  assign err       = err_q;
  assign dbg_state = state;

  i281_word_assembler u_asm (
    .clk     (clk),
    .reset   (reset),
    .in_byte (in_data),
    .load_b0 (load_b0),
    .load_b1 (load_b1),
    .fmt_ok  (fmt_ok),
    .word    (word)
  );

  always_comb begin
    state_nx = state;
    in_ready = 1'b1;
    wr_en    = 1'b0;
    busy     = 1'b1;
    cpu_hold = 1'b1;
    done     = 1'b0;
    load_b0  = 1'b0;
    load_b1  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        busy     = 1'b0;
        cpu_hold = (state == ST_ERROR);
        done     = (state == ST_DONE);
        if (consume && is_sync) state_nx = ST_COUNT;
      end
      ST_COUNT: if (consume) state_nx = count_bad ? ST_ERROR : ST_B0;
      ST_B0: begin
        load_b0 = consume;
        if (consume) state_nx = fmt_ok ? ST_B1 : ST_ERROR;
      end
      ST_B1: begin
        load_b1 = consume;
        if (consume) state_nx = ST_B2;
      end
      ST_B2: if (consume) state_nx = ST_WRITE;
      ST_WRITE: begin
        in_ready = 1'b0;
        wr_en    = 1'b1;
        state_nx = last_word ? ST_CHECK : ST_B0;
      end
      ST_CHECK: if (consume) state_nx = (in_data == csum) ? ST_DONE : ST_ERROR;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      err_q   <= ERR_NONE;
      count   <= '0;
      idx     <= '0;
      csum    <= 8'd0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: if (consume && is_sync) err_q <= ERR_NONE;
        ST_COUNT: if (consume) begin
          if (count_bad) begin
            err_q <= ERR_COUNT;
          end else begin
            count <= in_data[CNT_W-1:0];
            idx   <= '0;
            csum  <= 8'd0;
          end
        end
        ST_B0: if (consume) begin
          csum <= csum ^ in_data;
          if (!fmt_ok) err_q <= ERR_FORMAT;
        end
        ST_B1: if (consume) csum <= csum ^ in_data;
        // Address and word are captured here so they stay stable after the write.
        ST_B2: if (consume) begin
          csum    <= csum ^ in_data;
          wr_addr <= ADDR_W'(addr_sum % (CNT_W+1)'(WORDS));
          wr_data <= word;
        end
        ST_WRITE: idx <= idx + CNT_W'(1);
        ST_CHECK: if (consume && (in_data != csum)) err_q <= ERR_SUM;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i281_code_loader.sv
// Bench for i281_code_loader: two instances (base 16 and base 30) share one
// byte stream; a frame-level model predicts writes and final flags.
module tb_i281_code_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready0, wr_en0, cpu_hold0, busy0, done0;
  logic        in_ready1, wr_en1, cpu_hold1, busy1, done1;
  logic [4:0]  wr_addr0, wr_addr1;
  logic [16:0] wr_data0, wr_data1;
  logic [1:0]  err0, err1;
  logic [3:0]  st0, st1;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [21:0] exp_q0[$];
  logic [21:0] exp_q1[$];
  logic [7:0]  frm[$];
  logic [21:0] e0, e1;
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;

  i281_code_loader #(.BASE_ADDR(16)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .err(err0), .dbg_state(st0)
  );

  i281_code_loader #(.BASE_ADDR(30)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .err(err1), .dbg_state(st1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_en0) begin
        check("wr0_pending", 32'(exp_q0.size() > 0), 32'd1);
        if (exp_q0.size() > 0) begin
          e0 = exp_q0.pop_front();
          check("wr0_addr_data", {10'd0, wr_addr0, wr_data0}, {10'd0, e0});
        end
      end
      if (wr_en1) begin
        check("wr1_pending", 32'(exp_q1.size() > 0), 32'd1);
        if (exp_q1.size() > 0) begin
          e1 = exp_q1.pop_front();
          check("wr1_addr_data", {10'd0, wr_addr1, wr_data1}, {10'd0, e1});
        end
      end
    end
  end

  // Frame-level reference: walks the frame by its rules, queues the writes
  // for both bases, and reports how many bytes the loader will act on.
  task automatic model_frame(output int ns, output logic [1:0] e_err, output logic e_done);
    int n;
    logic [7:0] x, b0;
    logic [16:0] w;
    n = int'(frm[1]);
    e_err = 2'd0; e_done = 1'b0; x = 8'd0; ns = 2;
    if (n == 0 || n > 32) begin
      e_err = 2'd1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      b0 = frm[2+3*i];
      if (b0[7:1] != 7'd0) begin
        ns = 3 + 3*i;
        e_err = 2'd2;
        return;
      end
      w = {b0[0], frm[3+3*i], frm[4+3*i]};
      x = x ^ b0 ^ frm[3+3*i] ^ frm[4+3*i];
      exp_q0.push_back({5'((16 + i) % 32), w});
      exp_q1.push_back({5'((30 + i) % 32), w});
    end
    ns = 3 + 3*n;
    if (frm[2+3*n] == x) e_done = 1'b1;
    else e_err = 2'd3;
  endtask

  task automatic build_frame(input int n, input bit bad_fmt, input bit bad_chk);
    logic [7:0] x, b0, b1, b2;
    int bw;
    frm.delete();
    frm.push_back(8'hA5);
    frm.push_back(8'(n));
    if (n < 1 || n > 32) return;
    x = 8'd0;
    bw = bad_fmt ? int'($urandom_range(0, n-1)) : -1;
    for (int i = 0; i < n; i++) begin
      b0 = (i == bw) ? 8'($urandom_range(2, 255)) : {7'd0, 1'($urandom_range(0, 1))};
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      frm.push_back(b0); frm.push_back(b1); frm.push_back(b2);
      x = x ^ b0 ^ b1 ^ b2;
    end
    frm.push_back(bad_chk ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  // Called and returns at a negedge. A consumed third instruction byte must be
  // followed by a write strobe (and in_ready low) in the very next cycle.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit is_b2);
    bit acc;
    int tries;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data = b; in_valid = 1'b1; acc = 1'b0; tries = 0;
    while (!acc && tries < 10) begin
      acc = in_ready0;
      @(negedge clk);
      tries++;
    end
    in_valid = 1'b0;
    check("byte_accepted", 32'(acc), 32'd1);
    if (acc) begin
      check("wr_en_lat0", 32'(wr_en0), 32'(is_b2));
      check("wr_en_lat1", 32'(wr_en1), 32'(is_b2));
      check("in_ready_wr", 32'(in_ready0), 32'(!is_b2));
    end
  endtask

  task automatic check_flags(input bit ed, input logic [1:0] ee, input bit eh);
    check("done0", 32'(done0), 32'(ed));      check("done1", 32'(done1), 32'(ed));
    check("err0", 32'(err0), 32'(ee));        check("err1", 32'(err1), 32'(ee));
    check("hold0", 32'(cpu_hold0), 32'(eh));  check("hold1", 32'(cpu_hold1), 32'(eh));
    check("busy0", 32'(busy0), 32'd0);        check("busy1", 32'(busy1), 32'd0);
    check("idle_ready", 32'(in_ready0), 32'd1);
    check("q0_drained", 32'(exp_q0.size()), 32'd0);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);
  endtask

  task automatic check_reset();
    check("rst_ready", {30'd0, in_ready0, in_ready1}, 32'd3);
    check("rst_wr_en", {30'd0, wr_en0, wr_en1}, 32'd0);
    check("rst_addr", {22'd0, wr_addr0, wr_addr1}, 32'd0);
    check("rst_data0", 32'(wr_data0), 32'd0);
    check("rst_data1", 32'(wr_data1), 32'd0);
    check("rst_flags", {cpu_hold0, busy0, done0, err0, cpu_hold1, busy1, done1, err1}, 32'd0);
  endtask

  task automatic run_frame(input int gmin, input int gmax, input int junk);
    int ns, n;
    logic [1:0] ee;
    logic ed;
    bit b2;
    logic [7:0] jb;
    model_frame(ns, ee, ed);
    n = int'(frm[1]);
    for (int k = 0; k < ns; k++) begin
      b2 = (ee != 2'd1) && (k >= 4) && (k < 2 + 3*n) && (((k - 2) % 3) == 2);
      send_byte(frm[k], int'($urandom_range(gmin, gmax)), b2);
    end
    for (int j = 0; j < junk; j++) begin
      jb = 8'($urandom);
      if (jb == 8'hA5) jb = 8'h00;
      send_byte(jb, 0, 1'b0);
    end
    repeat (3) @(negedge clk);
    check_flags(ed, ee, !ed);
  endtask

  initial begin
    int ns, n;
    logic [1:0] ee;
    logic ed;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(negedge clk);
    check_reset();
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    frm = '{8'hA5, 8'h03, 8'h00, 8'hE0, 8'hF4, 8'h00, 8'h50, 8'h01, 8'h00, 8'hE0, 8'hEE, 8'h4B};
    run_frame(0, 0, 0);
    frm[11] = 8'h4C;
    run_frame(0, 0, 1);
    frm = '{8'hA5, 8'h00};
    run_frame(0, 0, 0);
    frm = '{8'hA5, 8'h21};
    run_frame(0, 0, 0);
    frm = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h00};
    run_frame(0, 0, 0);
    build_frame(4, 1'b0, 1'b0);
    run_frame(1, 1, 0);

    // Reset right after the second word's write strobe.
    build_frame(5, 1'b0, 1'b0);
    model_frame(ns, ee, ed);
    while (exp_q0.size() > 2) void'(exp_q0.pop_back());
    while (exp_q1.size() > 2) void'(exp_q1.pop_back());
    for (int k = 0; k < 8; k++) send_byte(frm[k], 0, (k == 4) || (k == 7));
    reset = 1'b1;
    @(negedge clk);
    check_reset();
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_flags(1'b0, 2'd0, 1'b0);
    build_frame(3, 1'b0, 1'b0);
    run_frame(0, 2, 0);
    build_frame(20, 1'b0, 1'b0);
    run_frame(0, 0, 0);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 9))
        0: n = 0;
        1: n = int'($urandom_range(33, 255));
        default: n = int'($urandom_range(1, 32));
      endcase
      build_frame(n, $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
      run_frame(0, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
